// File: rtl/sync_fifo_8x32_if.sv
// Handshake/data bundle for the 8x32 FIFO: requests and write data flow
// from the master to the FIFO; read data and status pulses flow back.
interface sync_fifo_8x32_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_ack;
    logic                  wr_err;
    logic                  rd_err;

    modport master (
        output rd_en, wr_en, din,
        input  dout, rd_ack, wr_err, rd_err
    );

    modport slave (
        input  rd_en, wr_en, din,
        output dout, rd_ack, wr_err, rd_err
    );
endinterface

// File: rtl/sync_fifo_8x32.sv
// Single-clock 8 x 32 FIFO. One write or one read per edge; a simultaneous
// write+read is a no-op. Read data, rd_ack and the error pulses are all
// registered and appear right after the sampling edge.
module sync_fifo_8x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    sync_fifo_8x32_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The "state" is the operation performed at the most recent edge; it
    // also drives the datapath update for the edge being decided.
    typedef enum logic [2:0] {
        INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR
    } op_e;

    op_e state, state_n;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head, tail, head_n, tail_n;
    logic [ADDR_WIDTH:0]   data_count, count_n;
    logic [DATA_WIDTH-1:0] dout_q, dout_n;
    logic                  rd_ack_q, wr_err_q, rd_err_q;
    logic                  rd_ack_n, wr_err_n, rd_err_n;
    logic                  empty, full;

    assign empty = (data_count == '0);
    assign full  = (data_count == (ADDR_WIDTH+1)'(DEPTH));

    // State register: remembers the operation just performed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else          state <= state_n;
    end

    // Next-state: decode the request pair against the current fill level
    always_comb begin
        state_n = NO_OP;
        case ({bus.wr_en, bus.rd_en})
            2'b10:   state_n = full  ? WR_ERROR : WRITE;
            2'b01:   state_n = empty ? RD_ERROR : READ;
            default: state_n = NO_OP;  // idle or simultaneous request
        endcase
    end

    // Output/datapath comb: next pointers, count, read data and pulses
    always_comb begin
        head_n   = head;
        tail_n   = tail;
        count_n  = data_count;
        dout_n   = dout_q;
        rd_ack_n = 1'b0;
        wr_err_n = 1'b0;
        rd_err_n = 1'b0;
        case (state_n)
            WRITE: begin
                tail_n  = tail + ADDR_WIDTH'(1);
                count_n = data_count + (ADDR_WIDTH+1)'(1);
            end
            READ: begin
                dout_n   = mem[head];
                head_n   = head + ADDR_WIDTH'(1);
                count_n  = data_count - (ADDR_WIDTH+1)'(1);
                rd_ack_n = 1'b1;
            end
            WR_ERROR: wr_err_n = 1'b1;
            RD_ERROR: rd_err_n = 1'b1;
            default: ;
        endcase
    end

    // Control/output registers; memory is left out of reset on purpose
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
            dout_q     <= '0;
            rd_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            data_count <= count_n;
            dout_q     <= dout_n;
            rd_ack_q   <= rd_ack_n;
            wr_err_q   <= wr_err_n;
            rd_err_q   <= rd_err_n;
        end
    end

    // Storage write on an accepted write only
    always_ff @(posedge clk) begin
        if (state_n == WRITE) mem[tail] <= bus.din;
    end

    assign bus.dout   = dout_q;
    assign bus.rd_ack = rd_ack_q;
    assign bus.wr_err = wr_err_q;
    assign bus.rd_err = rd_err_q;
endmodule

// File: tb/tb_sync_fifo_8x32.sv
// Directed bench for sync_fifo_8x32: a vector table covering fill, partial
// read, overflow, simultaneous request and drain/underflow, plus hand
// sequences for async reset at start and mid-stream.
module tb_sync_fifo_8x32;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    sync_fifo_8x32_if #(.DATA_WIDTH(32)) bus ();

    sync_fifo_8x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic        ack;
        logic        werr;
        logic        rerr;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [31:0] din,
                       input logic [31:0] dout, input logic ack,
                       input logic werr, input logic rerr, input logic [3:0] cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout;
        v.ack = ack; v.werr = werr; v.rerr = rerr; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status word {ack, wr_err, rd_err, count} for compact comparison
    function automatic logic [63:0] status(input logic a, input logic w,
                                           input logic r, input logic [3:0] c);
        return {57'd0, a, w, r, c};
    endfunction

    task automatic step(input logic wr, input logic rd, input logic [31:0] din);
        @(negedge clk);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        reset_n   = 1'b0;

        // Fill 1..7
        for (int i = 1; i <= 7; i++) add(1, 0, i, 0, 0, 0, 0, 4'(i));
        // Read two
        add(0, 1, 0, 1, 1, 0, 0, 6);
        add(0, 1, 0, 2, 1, 0, 0, 5);
        // Overflow: 8,9,A fit, the rest are rejected
        add(1, 0, 32'h8,  2, 0, 0, 0, 6);
        add(1, 0, 32'h9,  2, 0, 0, 0, 7);
        add(1, 0, 32'hA,  2, 0, 0, 0, 8);
        add(1, 0, 32'hB,  2, 0, 1, 0, 8);
        add(1, 0, 32'hD,  2, 0, 1, 0, 8);
        add(1, 0, 32'hE,  2, 0, 1, 0, 8);
        add(1, 0, 32'hF,  2, 0, 1, 0, 8);
        add(1, 0, 32'h10, 2, 0, 1, 0, 8);
        add(1, 0, 32'h11, 2, 0, 1, 0, 8);
        add(1, 0, 32'h12, 2, 0, 1, 0, 8);
        add(1, 0, 32'h13, 2, 0, 1, 0, 8);
        // Simultaneous request while full: nothing changes, no flags
        add(1, 1, 32'hDEAD, 2, 0, 0, 0, 8);
        // Drain: 3..A then underflow with dout holding A
        for (int i = 3; i <= 10; i++) add(0, 1, 0, i, 1, 0, 0, 4'(10 - i));
        for (int i = 0; i < 11; i++) add(0, 1, 0, 32'hA, 0, 0, 1, 0);
        // After wrap: one word, simultaneous with data present, idle, read back
        add(1, 0, 32'h55, 32'hA, 0, 0, 0, 1);
        add(1, 1, 32'h66, 32'hA, 0, 0, 0, 1);
        add(0, 0, 0,      32'hA, 0, 0, 0, 1);
        add(0, 1, 0,      32'h55, 1, 0, 0, 0);

        // Reset: async effect visible between edges
        #12;
        check("reset_dout",   64'(bus.dout), 64'd0);
        check("reset_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].wr, vecs[k].rd, vecs[k].din);
            check($sformatf("vec%0d_dout", k), 64'(bus.dout), 64'(vecs[k].dout));
            check($sformatf("vec%0d_status", k),
                  status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
                  status(vecs[k].ack, vecs[k].werr, vecs[k].rerr, vecs[k].cnt));
        end

        // Mid-stream reset: partial fill, a read to raise rd_ack, then reset
        step(1, 0, 32'h101);
        step(1, 0, 32'h202);
        step(1, 0, 32'h303);
        step(0, 1, 0);
        check("pre_reset_dout", 64'(bus.dout), 64'h101);
        check("pre_reset_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(1, 0, 0, 2));
        bus.rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_dout", 64'(bus.dout), 64'd0);
        check("midrst_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 0);
        check("post_reset_rd_dout", 64'(bus.dout), 64'd0);
        check("post_reset_rd_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(0, 0, 1, 0));
        // Sustained underflow keeps the flag high
        step(0, 1, 0);
        check("post_reset_rd2_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(0, 0, 1, 0));
        // Flag drops on an idle cycle
        step(0, 0, 0);
        check("idle_status", status(bus.rd_ack, bus.wr_err, bus.rd_err, dut.data_count),
              status(0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
